// File: rtl/delay_line_multi.sv
// Multi-channel programmable delay line. Every input is synchronised and edge-detected
// with a holdoff period. Each accepted edge is stamped with a deadline on a shared
// free-running counter. When the deadline comes up, the channel replays a modulated burst.

module delay_line_chan #(
  parameter int FIFO_DEPTH     = 512,
  parameter int CTR_WIDTH      = 18,
  parameter int HOLDOFF_CYCLES = 202,
  parameter int HALF_PERIOD    = 5,
  parameter int BURST_CYCLES   = 12
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 en,
  input  logic                 clear_flags,
  input  logic [CTR_WIDTH-1:0] ctr,
  input  logic [CTR_WIDTH-1:0] stamp,
  input  logic                 din,
  output logic                 out,
  output logic                 busy,
  output logic                 pending,
  output logic                 overflow,
  output logic                 collide
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam int PW = $clog2(HALF_PERIOD + 1);
  localparam int NW = $clog2(2 * BURST_CYCLES);

  typedef enum logic {ARMED, HOLDOFF} edge_t;
  typedef enum logic {IDLE, BURST} burst_t;

  logic s1, s2, s2_d;
  edge_t e_st, e_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic push_req, push_nxt;

  logic [CTR_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt, cnt_nxt;
  logic empty, full, pop, push_ok, ovf_set, trig_q;

  burst_t b_st, b_nxt;
  logic [PW-1:0] hp, hp_nxt;
  logic [NW-1:0] half, half_nxt;
  logic out_nxt, col_set;

  // two-flop synchroniser plus a delayed copy for rising-edge detection
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      s1 <= 1'b0; s2 <= 1'b0; s2_d <= 1'b0;
    end else begin
      s1 <= din; s2 <= s1; s2_d <= s2;
    end
  end

  // edge FSM: accept one rising edge, then wait for a run of low cycles before re-arming
  always_comb begin
    e_nxt    = e_st;
    hcnt_nxt = hcnt;
    push_nxt = 1'b0;
    case (e_st)
      ARMED: begin
        hcnt_nxt = '0;
        if (s2 && !s2_d) begin
          push_nxt = en;
          e_nxt    = HOLDOFF;
        end
      end
      default: begin
        if (s2) hcnt_nxt = '0;
        else begin
          hcnt_nxt = hcnt + HW'(1);
          if (hcnt_nxt == HW'(HOLDOFF_CYCLES)) e_nxt = ARMED;
        end
      end
    endcase
  end

  // edge FSM state; push_req is the registered edge-detect stage
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      e_st <= ARMED; hcnt <= '0; push_req <= 1'b0;
    end else begin
      e_st <= e_nxt; hcnt <= hcnt_nxt; push_req <= push_nxt;
    end
  end

  // deadline FIFO: a pop in the same cycle frees the slot needed by a push into a full FIFO
  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(FIFO_DEPTH));
  assign pop     = !empty && (mem[rd_ptr] == ctr);
  assign push_ok = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;

  // occupancy update for simultaneous push and pop
  always_comb begin
    cnt_nxt = cnt;
    if (push_ok && !pop)      cnt_nxt = cnt + (AW+1)'(1);
    else if (!push_ok && pop) cnt_nxt = cnt - (AW+1)'(1);
  end

  // deadline storage; emptiness is tracked by cnt, so no reset is needed here
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= stamp;
  end

  // FIFO pointers, count, registered pending and the trigger register
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      wr_ptr <= '0; rd_ptr <= '0; cnt <= '0; pending <= 1'b0; trig_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      cnt     <= cnt_nxt;
      pending <= (cnt_nxt != '0);
      trig_q  <= pop;
    end
  end

  // burst FSM: out starts high and toggles every HALF_PERIOD clocks for 2*BURST_CYCLES halves
  always_comb begin
    b_nxt    = b_st;
    hp_nxt   = hp;
    half_nxt = half;
    out_nxt  = out;
    col_set  = 1'b0;
    case (b_st)
      IDLE: begin
        if (trig_q) begin
          b_nxt = BURST; hp_nxt = '0; half_nxt = '0; out_nxt = 1'b1;
        end
      end
      default: begin
        col_set = trig_q;
        if (hp == PW'(HALF_PERIOD - 1)) begin
          hp_nxt = '0;
          if (half == NW'(2 * BURST_CYCLES - 1)) begin
            b_nxt = IDLE; out_nxt = 1'b0;
          end else begin
            half_nxt = half + NW'(1);
            out_nxt  = !out;
          end
        end else hp_nxt = hp + PW'(1);
      end
    endcase
  end

  // burst state, output register and sticky flags (a set beats a simultaneous clear)
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      b_st <= IDLE; hp <= '0; half <= '0; out <= 1'b0;
      overflow <= 1'b0; collide <= 1'b0;
    end else begin
      b_st <= b_nxt; hp <= hp_nxt; half <= half_nxt; out <= out_nxt;
      overflow <= ovf_set | (overflow & !clear_flags);
      collide  <= col_set | (collide & !clear_flags);
    end
  end

  assign busy = (b_st == BURST);
endmodule

module delay_line_multi #(
  parameter int NUM_CH         = 4,
  parameter int FIFO_DEPTH     = 512,
  parameter int CTR_WIDTH      = 18,
  parameter int DEFAULT_DELAY  = 135000,
  parameter int HOLDOFF_CYCLES = 202,
  parameter int HALF_PERIOD    = 5,
  parameter int BURST_CYCLES   = 12
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 en,
  input  logic [CTR_WIDTH-1:0] delay_cycles,
  input  logic                 delay_load,
  input  logic                 clear_flags,
  input  logic [NUM_CH-1:0]    in,
  output logic [NUM_CH-1:0]    out,
  output logic [NUM_CH-1:0]    busy,
  output logic [NUM_CH-1:0]    pending,
  output logic [NUM_CH-1:0]    overflow,
  output logic [NUM_CH-1:0]    collide
);
  logic [CTR_WIDTH-1:0] ctr, delay_act, stamp;

  // the 4 subtracted clocks cover sync (2), edge detect (1) and the output register (1)
  assign stamp = ctr + delay_act - CTR_WIDTH'(4);

  // shared timestamp counter and active delay, clamped to the pipeline minimum of 8
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      ctr       <= '0;
      delay_act <= CTR_WIDTH'(DEFAULT_DELAY);
    end else begin
      ctr <= ctr + CTR_WIDTH'(1);
      if (delay_load)
        delay_act <= (delay_cycles < CTR_WIDTH'(8)) ? CTR_WIDTH'(8) : delay_cycles;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    delay_line_chan #(
      .FIFO_DEPTH(FIFO_DEPTH), .CTR_WIDTH(CTR_WIDTH), .HOLDOFF_CYCLES(HOLDOFF_CYCLES),
      .HALF_PERIOD(HALF_PERIOD), .BURST_CYCLES(BURST_CYCLES)
    ) u_ch (
      .clk(clk), .n_reset(n_reset), .en(en), .clear_flags(clear_flags),
      .ctr(ctr), .stamp(stamp), .din(in[c]),
      .out(out[c]), .busy(busy[c]), .pending(pending[c]),
      .overflow(overflow[c]), .collide(collide[c])
    );
  end
endmodule

// File: tb/tb_delay_line_multi.sv
// Directed bench for delay_line_multi, scaled down so every scenario fits a short run.
module tb_delay_line_multi;
  localparam int NCH = 4;
  localparam int CW  = 12;

  logic clk = 1'b0;
  logic n_reset, en, delay_load, clear_flags;
  logic [CW-1:0] delay_cycles;
  logic [NCH-1:0] din, out, busy, pending, overflow, collide;
  logic [NCH-1:0] busy_prev = '0;
  int bstart [NCH];
  int n_cmp = 0, n_err = 0;

  delay_line_multi #(
    .NUM_CH(NCH), .FIFO_DEPTH(4), .CTR_WIDTH(CW), .DEFAULT_DELAY(600),
    .HOLDOFF_CYCLES(20), .HALF_PERIOD(5), .BURST_CYCLES(12)
  ) dut (
    .clk(clk), .n_reset(n_reset), .en(en), .delay_cycles(delay_cycles),
    .delay_load(delay_load), .clear_flags(clear_flags), .in(din),
    .out(out), .busy(busy), .pending(pending), .overflow(overflow), .collide(collide)
  );

  always #5 clk = ~clk;

  // count burst starts per channel
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++)
      if (busy[c] && !busy_prev[c]) bstart[c] = bstart[c] + 1;
    busy_prev <= busy;
  end

  task automatic load_delay(input int d);
    @(negedge clk); delay_cycles = CW'(d); delay_load = 1'b1;
    @(negedge clk); delay_load = 1'b0;
  endtask

  task automatic pulse(input int ch, input int w);
    @(negedge clk); din[ch] = 1'b1;
    repeat (w) @(negedge clk);
    din[ch] = 1'b0;
  endtask

  // Pulse shape hi1 / lo / hi2; lat = clocks from the sampling edge to out rising.
  task automatic time_pulse(input int ch, input int hi1, input int lo, input int hi2,
                            input int limit, output int lat, output logic pend);
    int n, endp;
    bit seen;
    n = 0; seen = 0; lat = -1; pend = 1'b0; endp = hi1 + lo + hi2;
    @(negedge clk); din[ch] = 1'b1;
    @(posedge clk);
    while (n < limit && !(seen && n >= endp)) begin
      @(posedge clk); #1; n++;
      if (n == hi1) din[ch] = 1'b0;
      if (hi2 > 0 && n == hi1 + lo) din[ch] = 1'b1;
      if (hi2 > 0 && n == endp) din[ch] = 1'b0;
      if (n == 5) pend = pending[ch];
      if (!seen && out[ch]) begin seen = 1; lat = n; end
    end
    din[ch] = 1'b0;
  endtask

  task automatic test_reset;
    n_reset = 1'b0; en = 1'b1; delay_load = 1'b0; clear_flags = 1'b0;
    delay_cycles = '0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    if ({out, busy, pending, overflow, collide} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", {out, busy, pending, overflow, collide});
    end
    n_cmp++;
    @(negedge clk); n_reset = 1'b1;
  endtask

  task automatic test_default;
    int lat, bad, b0;
    logic pend;
    bad = 0; b0 = bstart[0];
    time_pulse(0, 100, 0, 0, 2000, lat, pend);
    if (lat !== 600) begin n_err++; $display("FAIL default_latency: got %0d want 600", lat); end
    n_cmp++;
    if (pend !== 1'b1) begin n_err++; $display("FAIL default_pending: got %b want 1", pend); end
    n_cmp++;
    for (int j = 0; j < 120; j++) begin
      if (out[0] !== ((j / 5) % 2 == 0)) bad++;
      if (busy[0] !== 1'b1) bad++;
      if (out[3:1] !== 3'b000) bad++;
      @(posedge clk); #1;
    end
    if (bad != 0) begin n_err++; $display("FAIL default_waveform: got %0d bad samples want 0", bad); end
    n_cmp++;
    if ({out[0], busy[0], pending[0]} !== 3'b000) begin
      n_err++; $display("FAIL default_end: got %b want 000", {out[0], busy[0], pending[0]});
    end
    n_cmp++;
    if (bstart[0] - b0 !== 1) begin n_err++; $display("FAIL default_bursts: got %0d want 1", bstart[0] - b0); end
    n_cmp++;
  endtask

  task automatic test_holdoff;
    int lat, b1;
    logic pend;
    load_delay(1000);
    b1 = bstart[1];
    time_pulse(1, 50, 10, 50, 2000, lat, pend);
    if (lat !== 1000) begin n_err++; $display("FAIL holdoff_latency: got %0d want 1000", lat); end
    n_cmp++;
    repeat (400) @(negedge clk);
    if (bstart[1] - b1 !== 1) begin n_err++; $display("FAIL holdoff_bursts: got %0d want 1", bstart[1] - b1); end
    n_cmp++;
    if ({overflow[1], collide[1]} !== 2'b00) begin
      n_err++; $display("FAIL holdoff_flags: got %b want 00", {overflow[1], collide[1]});
    end
    n_cmp++;
  endtask

  task automatic test_overflow;
    int lat, b2;
    logic pend;
    load_delay(5);
    b2 = bstart[2];
    time_pulse(2, 50, 0, 0, 500, lat, pend);
    if (lat !== 8) begin n_err++; $display("FAIL min_delay_latency: got %0d want 8", lat); end
    n_cmp++;
    for (int i = 0; i < 5; i++) begin
      repeat (200) @(negedge clk);
      pulse(2, 50);
    end
    repeat (300) @(negedge clk);
    if (bstart[2] - b2 !== 6) begin n_err++; $display("FAIL short_bursts: got %0d want 6", bstart[2] - b2); end
    n_cmp++;
    if (overflow[2] !== 1'b0) begin n_err++; $display("FAIL short_overflow: got %b want 0", overflow[2]); end
    n_cmp++;
    load_delay(3000);
    b2 = bstart[2];
    for (int i = 0; i < 5; i++) begin
      pulse(2, 50);
      if (i == 3 && overflow[2] !== 1'b0) begin
        n_err++; $display("FAIL fifo_fill_overflow: got %b want 0", overflow[2]);
      end
      if (i == 3) n_cmp++;
      if (i < 4) repeat (200) @(negedge clk);
    end
    if (overflow[2] !== 1'b1) begin n_err++; $display("FAIL fifo_overflow: got %b want 1", overflow[2]); end
    n_cmp++;
    if (pending[2] !== 1'b1) begin n_err++; $display("FAIL fifo_pending: got %b want 1", pending[2]); end
    n_cmp++;
    repeat (3000) @(negedge clk);
    if (bstart[2] - b2 !== 4) begin n_err++; $display("FAIL fifo_bursts: got %0d want 4", bstart[2] - b2); end
    n_cmp++;
    if (pending[2] !== 1'b0) begin n_err++; $display("FAIL fifo_drained: got %b want 0", pending[2]); end
    n_cmp++;
    @(negedge clk); clear_flags = 1'b1;
    @(negedge clk); clear_flags = 1'b0;
    if (overflow[2] !== 1'b0) begin n_err++; $display("FAIL overflow_clear: got %b want 0", overflow[2]); end
    n_cmp++;
  endtask

  task automatic test_collide;
    int b3;
    load_delay(1000);
    b3 = bstart[3];
    pulse(3, 50);
    repeat (50) @(negedge clk);
    pulse(3, 50);
    repeat (1300) @(negedge clk);
    if (collide[3] !== 1'b1) begin n_err++; $display("FAIL collide_set: got %b want 1", collide[3]); end
    n_cmp++;
    if (bstart[3] - b3 !== 1) begin n_err++; $display("FAIL collide_bursts: got %0d want 1", bstart[3] - b3); end
    n_cmp++;
    if (pending[3] !== 1'b0) begin n_err++; $display("FAIL collide_pending: got %b want 0", pending[3]); end
    n_cmp++;
    @(negedge clk); clear_flags = 1'b1;
    @(negedge clk); clear_flags = 1'b0;
    if (collide[3] !== 1'b0) begin n_err++; $display("FAIL collide_clear: got %b want 0", collide[3]); end
    n_cmp++;
  endtask

  task automatic test_wrap;
    int lat;
    logic pend;
    @(negedge clk); n_reset = 1'b0;
    @(negedge clk); n_reset = 1'b1;
    load_delay(100);
    // sampling edge lands near ctr = 4077, so the stored deadline wraps past 0
    repeat (4073) @(negedge clk);
    time_pulse(0, 30, 0, 0, 400, lat, pend);
    if (lat !== 100) begin n_err++; $display("FAIL wrap_latency: got %0d want 100", lat); end
    n_cmp++;
    repeat (150) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int b1;
    load_delay(300);
    for (int i = 0; i < 4; i++) begin
      pulse(1, 30);
      repeat (30) @(negedge clk);
    end
    repeat (70) @(negedge clk);
    if ({busy[1], pending[1]} !== 2'b11) begin
      n_err++; $display("FAIL mid_busy_pending: got %b want 11", {busy[1], pending[1]});
    end
    n_cmp++;
    b1 = bstart[1];
    n_reset = 1'b0;
    @(posedge clk); #1;
    if ({out, busy, pending} !== '0) begin
      n_err++; $display("FAIL mid_reset_clear: got %h want 0", {out, busy, pending});
    end
    n_cmp++;
    @(negedge clk); n_reset = 1'b1;
    repeat (1500) @(negedge clk);
    if (bstart[1] !== b1 || out !== '0) begin
      n_err++; $display("FAIL mid_no_replay: got %0d bursts out %b want 0 bursts out 0", bstart[1] - b1, out);
    end
    n_cmp++;
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) bstart[c] = 0;
    test_reset;
    test_default;
    test_holdoff;
    test_overflow;
    test_collide;
    test_wrap;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
